// File: rtl/id_fwd_stage.sv
// id_fwd_stage: MIPS logic/shift decode with multi-port operand forwarding, load-use stall and a registered ID->EX handshake.
module id_fwd_stage #(
  parameter int FWD_PORTS = 2,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   pc_i,
  input  logic [31:0]                   inst_i,
  output logic [4:0]                    reg1_addr_o,
  output logic [4:0]                    reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_wen,
  input  logic [FWD_PORTS-1:0]          fwd_rdy,
  input  logic [5*FWD_PORTS-1:0]        fwd_waddr,
  input  logic [DATA_W*FWD_PORTS-1:0]   fwd_wdata,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    aluop_o,
  output logic [2:0]                    alusel_o,
  output logic [4:0]                    wreg_addr_o,
  output logic                          wreg_enable_o,
  output logic [DATA_W-1:0]             reg1_data_o,
  output logic [DATA_W-1:0]             reg2_data_o,
  output logic [31:0]                   pc_o,
  output logic                          inv_inst_o
);
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  typedef struct packed {
    logic              valid;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [4:0]        waddr;
    logic              wen;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [31:0]       pc;
    logic              inv;
  } stage_t;

  stage_t r_q;
  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt, w_rd, w_sa;
  logic [15:0] w_imm;
  logic [7:0] w_aluop;
  logic [2:0] w_alusel;
  logic [4:0] w_waddr;
  logic w_wen, w_re1, w_re2, w_inv, w_stall, w_load;
  logic [DATA_W-1:0] w_imm1, w_imm2, w_d1, w_d2;
  logic [DATA_W:0] w_src1, w_src2;

  // {stall, data}: register 0 is hardwired, otherwise the youngest matching writer wins
  function automatic logic [DATA_W:0] resolve(
    input logic [4:0]                  a,
    input logic [DATA_W-1:0]           rf,
    input logic [FWD_PORTS-1:0]        wen,
    input logic [FWD_PORTS-1:0]        rdy,
    input logic [5*FWD_PORTS-1:0]      waddr,
    input logic [DATA_W*FWD_PORTS-1:0] wdata
  );
    logic [DATA_W:0] r;
    r = {1'b0, rf};
    for (int p = FWD_PORTS - 1; p >= 0; p--)
      if (wen[p] && waddr[5*p +: 5] == a) r = {~rdy[p], wdata[DATA_W*p +: DATA_W]};
    return (a == 5'd0) ? '0 : r;
  endfunction

  assign w_op        = inst_i[31:26];
  assign w_rs        = inst_i[25:21];
  assign w_rt        = inst_i[20:16];
  assign w_rd        = inst_i[15:11];
  assign w_sa        = inst_i[10:6];
  assign w_funct     = inst_i[5:0];
  assign w_imm       = inst_i[15:0];
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  always_comb begin
    w_aluop  = EXE_NOP_OP;
    w_alusel = EXE_RES_NOP;
    w_wen    = 1'b0;
    w_waddr  = 5'd0;
    w_re1    = 1'b0;
    w_re2    = 1'b0;
    w_imm1   = '0;
    w_imm2   = '0;
    w_inv    = 1'b1;
    if (inst_i == 32'd0 || w_op == 6'h33 || (w_op == 6'h00 && w_funct == 6'h0f)) begin
      w_inv = 1'b0;
    end else if (inst_i[31:21] == 11'd0 && (w_funct == 6'h00 || w_funct == 6'h02 || w_funct == 6'h03)) begin
      w_inv    = 1'b0;
      w_re2    = 1'b1;
      w_imm1   = DATA_W'(w_sa);
      w_wen    = 1'b1;
      w_waddr  = w_rd;
      w_alusel = EXE_RES_SHIFT;
      w_aluop  = (w_funct == 6'h00) ? EXE_SLL_OP : (w_funct == 6'h02) ? EXE_SRL_OP : EXE_SRA_OP;
    end else if (w_op == 6'h00 && w_sa == 5'd0 &&
                 (w_funct[5:2] == 4'b1001 || w_funct == 6'h04 || w_funct == 6'h06 || w_funct == 6'h07)) begin
      w_inv    = 1'b0;
      w_re1    = 1'b1;
      w_re2    = 1'b1;
      w_wen    = 1'b1;
      w_waddr  = w_rd;
      w_alusel = w_funct[5] ? EXE_RES_LOGIC : EXE_RES_SHIFT;
      w_aluop  = (w_funct == 6'h24) ? EXE_AND_OP : (w_funct == 6'h25) ? EXE_OR_OP :
                 (w_funct == 6'h26) ? EXE_XOR_OP : (w_funct == 6'h27) ? EXE_NOR_OP :
                 (w_funct == 6'h04) ? EXE_SLL_OP : (w_funct == 6'h06) ? EXE_SRL_OP : EXE_SRA_OP;
    end else if (w_op[5:2] == 4'b0011) begin
      w_inv    = 1'b0;
      w_re1    = 1'b1;
      w_wen    = 1'b1;
      w_waddr  = w_rt;
      w_alusel = EXE_RES_LOGIC;
      w_aluop  = (w_op == 6'h0c) ? EXE_AND_OP : (w_op == 6'h0e) ? EXE_XOR_OP : EXE_OR_OP;
      w_imm2   = (w_op == 6'h0f) ? DATA_W'({w_imm, 16'h0}) : DATA_W'(w_imm);
    end
  end

  assign w_src1  = resolve(w_rs, reg1_data_i, fwd_wen, fwd_rdy, fwd_waddr, fwd_wdata);
  assign w_src2  = resolve(w_rt, reg2_data_i, fwd_wen, fwd_rdy, fwd_waddr, fwd_wdata);
  assign w_d1    = w_re1 ? w_src1[DATA_W-1:0] : w_imm1;
  assign w_d2    = w_re2 ? w_src2[DATA_W-1:0] : w_imm2;
  assign w_stall = (w_re1 & w_src1[DATA_W]) | (w_re2 & w_src2[DATA_W]);
  assign in_ready = ~rst & ~w_stall & (~r_q.valid | out_ready);
  assign w_load  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush || (!w_load && out_ready))
      r_q <= '0;
    else if (w_load)
      r_q <= '{valid: 1'b1, aluop: w_aluop, alusel: w_alusel, waddr: w_waddr, wen: w_wen,
               d1: w_d1, d2: w_d2, pc: pc_i, inv: w_inv};
  end

  assign out_valid     = r_q.valid;
  assign aluop_o       = r_q.aluop;
  assign alusel_o      = r_q.alusel;
  assign wreg_addr_o   = r_q.waddr;
  assign wreg_enable_o = r_q.wen;
  assign reg1_data_o   = r_q.d1;
  assign reg2_data_o   = r_q.d2;
  assign pc_o          = r_q.pc;
  assign inv_inst_o    = r_q.inv;
endmodule

// File: tb/tb_id_fwd_stage.sv
// tb_id_fwd_stage: directed decode/forward vectors plus stall, backpressure, flush and reset sequences.
module tb_id_fwd_stage;
  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7c, OP_SRA = 8'h03;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, reg1_data_o, reg2_data_o, pc_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, wreg_addr_o;
  logic [1:0] fwd_wen, fwd_rdy;
  logic [9:0] fwd_waddr;
  logic [63:0] fwd_wdata;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic wreg_enable_o, inv_inst_o;
  int checks = 0, failures = 0;

  id_fwd_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wen(fwd_wen), .fwd_rdy(fwd_rdy), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .wreg_addr_o(wreg_addr_o), .wreg_enable_o(wreg_enable_o), .reg1_data_o(reg1_data_o),
    .reg2_data_o(reg2_data_o), .pc_o(pc_o), .inv_inst_o(inv_inst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, rf1, rf2;
    logic [1:0]  wen, rdy;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  aluop;
    logic [2:0]  sel;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] d1, d2;
    logic        inv;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " payload"}, {aluop_o, alusel_o, wreg_addr_o, wreg_enable_o, inv_inst_o, pc_o[15:0]}, 64'd0);
    chk({tag, " data"}, {reg1_data_o, reg2_data_o}, 64'd0);
  endtask

  initial begin
    v[0]  = '{32'h34011234, 32'hDEAD, 32'h0, 2'b00, 2'b11, 10'h0, 64'h0, OP_OR, S_LOG, 5'd1, 1'b1, 32'h0, 32'h1234, 1'b0};
    v[1]  = '{32'h00221825, 32'h11111111, 32'h0F, 2'b11, 2'b11, {5'd1, 5'd1}, {32'h55550000, 32'hAAAA0000},
              OP_OR, S_LOG, 5'd3, 1'b1, 32'hAAAA0000, 32'h0F, 1'b0};
    v[2]  = '{32'h3C04BEEF, 32'h0, 32'h0, 2'b00, 2'b11, 10'h0, 64'h0, OP_OR, S_LOG, 5'd4, 1'b1, 32'h0, 32'hBEEF0000, 1'b0};
    v[3]  = '{32'h000628C0, 32'h0, 32'h1, 2'b00, 2'b11, 10'h0, 64'h0, OP_SLL, S_SH, 5'd5, 1'b1, 32'h3, 32'h1, 1'b0};
    v[4]  = '{32'hFC000000, 32'h5, 32'h6, 2'b00, 2'b11, 10'h0, 64'h0, OP_NOP, S_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1};
    v[5]  = '{32'h01093824, 32'h12345678, 32'h3, 2'b10, 2'b11, {5'd9, 5'd0}, {32'h99, 32'h0},
              OP_AND, S_LOG, 5'd7, 1'b1, 32'h12345678, 32'h99, 1'b0};
    v[6]  = '{32'h016C5007, 32'h4, 32'h80000000, 2'b00, 2'b11, {5'd0, 5'd11}, {32'h0, 32'hBAD},
              OP_SRA, S_SH, 5'd10, 1'b1, 32'h4, 32'h80000000, 1'b0};
    v[7]  = '{32'h3862FFFF, 32'h7, 32'h0, 2'b11, 2'b01, {5'd3, 5'd3}, {32'h1, 32'hF0F0},
              OP_XOR, S_LOG, 5'd2, 1'b1, 32'hF0F0, 32'hFFFF, 1'b0};
    v[8]  = '{32'h0000000F, 32'h1, 32'h2, 2'b00, 2'b11, 10'h0, 64'h0, OP_NOP, S_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0};
    v[9]  = '{32'hCC000000, 32'h1, 32'h2, 2'b00, 2'b11, 10'h0, 64'h0, OP_NOP, S_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0};
    v[10] = '{32'h00000000, 32'h1, 32'h2, 2'b00, 2'b11, 10'h0, 64'h0, OP_NOP, S_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0};
    v[11] = '{32'h34C50001, 32'h100, 32'h9, 2'b01, 2'b10, {5'd0, 5'd5}, {32'h0, 32'hEEEE},
              OP_OR, S_LOG, 5'd5, 1'b1, 32'h100, 32'h1, 1'b0};
    v[12] = '{32'h00400827, 32'h3, 32'h5555, 2'b01, 2'b10, {5'd0, 5'd0}, {32'h0, 32'hFFFF},
              OP_NOR, S_LOG, 5'd1, 1'b1, 32'h3, 32'h0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
    reg1_data_i = 32'h0; reg2_data_i = 32'h0; fwd_wen = 2'b00; fwd_rdy = 2'b11; fwd_waddr = 10'h0; fwd_wdata = 64'h0;
    tick();
    tick();
    chk("in_ready in reset", 64'(in_ready), 64'd0);
    chk_empty("reset");
    rst = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      inst_i = v[i].inst; reg1_data_i = v[i].rf1; reg2_data_i = v[i].rf2; pc_i = 32'h1000 + 32'(i * 4);
      fwd_wen = v[i].wen; fwd_rdy = v[i].rdy; fwd_waddr = v[i].waddr; fwd_wdata = v[i].wdata;
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d reg addrs", i), {reg1_addr_o, reg2_addr_o}, {v[i].inst[25:21], v[i].inst[20:16]});
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d ctl", i), {aluop_o, alusel_o, wreg_addr_o, wreg_enable_o, inv_inst_o},
          {v[i].aluop, v[i].sel, v[i].wa, v[i].we, v[i].inv});
      chk($sformatf("v%0d reg1", i), 64'(reg1_data_o), 64'(v[i].d1));
      chk($sformatf("v%0d reg2", i), 64'(reg2_data_o), 64'(v[i].d2));
      chk($sformatf("v%0d pc", i), 64'(pc_o), 64'(32'h1000 + 32'(i * 4)));
      tick();
      chk_empty($sformatf("v%0d drain", i));
    end

    // load-use stall on rt, then release with the produced value
    inst_i = 32'h00221825; reg1_data_i = 32'h1; reg2_data_i = 32'h0F; pc_i = 32'h2000;
    fwd_wen = 2'b01; fwd_rdy = 2'b10; fwd_waddr = {5'd0, 5'd2}; fwd_wdata = 64'h0; in_valid = 1'b1;
    #1;
    chk("stall in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("stall out_valid", 64'(out_valid), 64'd0);
    fwd_rdy = 2'b11; fwd_wdata = 64'h77;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; fwd_wen = 2'b00;
    chk("release out_valid", 64'(out_valid), 64'd1);
    chk("release data", {reg1_data_o, reg2_data_o}, {32'h1, 32'h77});
    tick();

    // invalid instruction held under backpressure, then flushed along with a new input
    inst_i = 32'hFC000000; pc_i = 32'h3000; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d state", c), {out_valid, inv_inst_o, wreg_enable_o, aluop_o, pc_o},
          {1'b1, 1'b1, 1'b0, OP_NOP, 32'h3000});
      chk($sformatf("hold%0d in_ready", c), 64'(in_ready), 64'd0);
      tick();
    end
    inst_i = 32'h34011234; pc_i = 32'h3004; out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty("flush");

    // reset while a held instruction faces a stalled successor
    inst_i = 32'h34011234; pc_i = 32'h4000; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    inst_i = 32'h00221825; fwd_wen = 2'b01; fwd_rdy = 2'b10; fwd_waddr = {5'd0, 5'd2}; rst = 1'b1;
    tick();
    chk_empty("stall reset");
    chk("stall reset in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("reset held in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; fwd_wen = 2'b00; out_ready = 1'b1;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
